// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: turns single-cycle hazard flags into per-stage
// enables, adding the branch-after-load and mult/div stall sequences plus a stall counter.
module pipe_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_wait,
    input  logic        md_req,
    input  logic        br_dep_load,
    input  logic        load_use,
    input  logic        br_dep_alu,
    input  logic        br_taken,
    input  logic        jump,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_freeze,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             stall;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stall && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so every path assigns every variable; no latches.
        state_next = state;
        cnt_next   = cnt;
        if (!mem_wait) begin
            unique case (state)
                RUN: begin
                    if (md_req) begin
                        if (MD_LAT > 1) begin
                            state_next = MD_WAIT;
                            cnt_next   = CNT_W'(MD_LAT - 1);
                        end
                    end else if (br_dep_load) begin
                        state_next = BR_WAIT;
                    end
                end
                BR_WAIT: state_next = RUN;
                MD_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Output logic; reset forces a flush plus bubble so nothing leaks out of a reset cycle
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        stall        = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else begin
            if (state != RUN || md_req || br_dep_load || load_use || br_dep_alu)
                stall = 1'b1;
            if (stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else begin
                if_id_flush = br_taken | jump;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; two instances cover MD_LAT=4 and MD_LAT=8
// from the same stimulus.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic reset, mem_wait, md_req, br_dep_load, load_use, br_dep_alu, br_taken, jump;

    logic        pc4, ifw4, fl4, bub4, frz4;
    logic [1:0]  st4;
    logic [15:0] sc4;
    logic        pc8, ifw8, fl8, bub8, frz8;
    logic [1:0]  st8;
    logic [15:0] sc8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MD_LAT(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .mem_wait(mem_wait), .md_req(md_req),
        .br_dep_load(br_dep_load), .load_use(load_use), .br_dep_alu(br_dep_alu),
        .br_taken(br_taken), .jump(jump),
        .pc_write(pc4), .if_id_write(ifw4), .if_id_flush(fl4), .id_ex_bubble(bub4),
        .pipe_freeze(frz4), .state_o(st4), .stall_cycles(sc4)
    );

    pipe_stall_ctrl #(.MD_LAT(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .mem_wait(mem_wait), .md_req(md_req),
        .br_dep_load(br_dep_load), .load_use(load_use), .br_dep_alu(br_dep_alu),
        .br_taken(br_taken), .jump(jump),
        .pc_write(pc8), .if_id_write(ifw8), .if_id_flush(fl8), .id_ex_bubble(bub8),
        .pipe_freeze(frz8), .state_o(st8), .stall_cycles(sc8)
    );

    // Expected output vectors: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, state}
    localparam logic [6:0] NORM   = 7'b11000_00;
    localparam logic [6:0] FLUSH  = 7'b11100_00;
    localparam logic [6:0] ST_RUN = 7'b00010_00;
    localparam logic [6:0] ST_BR  = 7'b00010_01;
    localparam logic [6:0] ST_MD  = 7'b00010_10;
    localparam logic [6:0] FRZ_RN = 7'b00001_00;
    localparam logic [6:0] FRZ_MD = 7'b00001_10;
    localparam logic [4:0] RST5   = 5'b00110;

    // Input vectors: {mem_wait, md_req, br_dep_load, load_use, br_dep_alu, br_taken, jump}
    localparam logic [6:0] I_IDLE = 7'b0000000;

    function automatic logic [6:0] obs(input bit sel8);
        return sel8 ? {pc8, ifw8, fl8, bub8, frz8, st8} : {pc4, ifw4, fl4, bub4, frz4, st4};
    endfunction

    task automatic drive(input logic [6:0] v);
        {mem_wait, md_req, br_dep_load, load_use, br_dep_alu, br_taken, jump} = v;
    endtask

    task automatic chk_out(input string tag, input bit sel8, input logic [6:0] exp);
        logic [6:0] o;
        o = obs(sel8);
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input bit sel8, input logic [15:0] exp);
        logic [15:0] o;
        o = sel8 ? sc8 : sc4;
        checks++;
        assert (o === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    // One cycle: apply inputs just after the edge, check outputs at the falling edge.
    task automatic cyc(input logic [6:0] in, input string tag, input bit sel8, input logic [6:0] exp);
        drive(in);
        @(negedge clk);
        chk_out(tag, sel8, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        logic [4:0] o;
        reset = 1'b1;
        drive(I_IDLE);
        @(negedge clk);
        o = obs(1'b0) >> 2;
        checks++;
        assert (o === RST5) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, RST5);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(I_IDLE);

        // Reset and idle
        do_reset("reset_outputs");
        drive(I_IDLE);
        @(negedge clk);
        chk_out("idle_after_reset", 1'b0, NORM);
        chk_cnt("cnt_after_reset", 1'b0, 16'd0);
        @(posedge clk);
        #1;

        // Single load-use stall
        cyc(7'b0001000, "load_use_stall", 1'b0, ST_RUN);
        cyc(I_IDLE, "load_use_release", 1'b0, NORM);
        chk_cnt("load_use_count", 1'b0, 16'd1);

        // Freeze in RUN with a pending hazard: nothing counted, state held
        cyc(7'b1001000, "freeze_run", 1'b0, FRZ_RN);
        chk_cnt("freeze_not_counted", 1'b0, 16'd1);

        // Branch after load wins over load_use: two stalls
        do_reset("reset_before_brload");
        cyc(7'b0011000, "brload_t0", 1'b0, ST_RUN);
        cyc(7'b0000010, "brload_t1_ignores", 1'b0, ST_BR);
        cyc(I_IDLE, "brload_t2", 1'b0, NORM);
        chk_cnt("brload_count", 1'b0, 16'd2);

        // Mult/div with MD_LAT=4 and one freeze cycle inside the sequence
        do_reset("reset_before_md4");
        cyc(7'b0100000, "md4_t0", 1'b0, ST_RUN);
        cyc(7'b0100000, "md4_t1", 1'b0, ST_MD);
        cyc(7'b1000000, "md4_t2_freeze", 1'b0, FRZ_MD);
        cyc(7'b0000010, "md4_t3_no_flush", 1'b0, ST_MD);
        cyc(I_IDLE, "md4_t4", 1'b0, ST_MD);
        cyc(I_IDLE, "md4_t5_normal", 1'b0, NORM);
        chk_cnt("md4_count", 1'b0, 16'd4);

        // Stall beats flush, then the re-presented branch flushes
        do_reset("reset_before_flush");
        cyc(7'b0000110, "brtaken_alu_stall", 1'b0, ST_RUN);
        cyc(7'b0000010, "brtaken_flush", 1'b0, FLUSH);
        cyc(7'b0000001, "jump_flush", 1'b0, FLUSH);
        chk_cnt("flush_count", 1'b0, 16'd1);

        // Reset abandons a MD_LAT=8 sequence
        do_reset("reset_before_md8");
        cyc(7'b0100000, "md8_t0", 1'b1, ST_RUN);
        cyc(7'b0100000, "md8_t1", 1'b1, ST_MD);
        cyc(I_IDLE, "md8_t2", 1'b1, ST_MD);
        do_reset("md8_t3_reset");
        drive(I_IDLE);
        @(negedge clk);
        chk_out("md8_t4_run", 1'b1, NORM);
        chk_cnt("md8_count_cleared", 1'b1, 16'd0);
        @(posedge clk);
        #1;

        // Saturation of the stall counter
        do_reset("reset_before_sat");
        drive(7'b0001000);
        repeat (65534) @(posedge clk);
        #1;
        chk_cnt("sat_preload", 1'b0, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk_cnt("sat_hold", 1'b0, 16'hFFFF);
        drive(I_IDLE);
        @(negedge clk);
        chk_out("sat_normal", 1'b0, NORM);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall/flush sequencer for the 5-stage MIPS core. It takes single-cycle hazard flags from the ID-stage hazard logic and produces the actual per-stage control: PC/IF-ID write enables, the IF/ID flush, the ID/EX bubble and a global freeze. It adds multi-cycle sequencing: a 2-cycle branch-after-load stall, a counted stall for the multi-cycle multiply/divide unit, and a saturating stall-cycle performance counter.

## Interface
- MD_LAT, 4: total stall cycles for a mult/div issued in ID; legal range 1..15.
- CNT_W, 4: width of the mult/div countdown counter; must hold MD_LAT.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_wait  in  1  memory not ready; freeze the whole pipe.
- md_req  in  1  mult/div instruction in ID.
- br_dep_load  in  1  branch in ID depends on a load in EX.
- load_use  in  1  load in EX feeds the instruction in ID.
- br_dep_alu  in  1  branch in ID depends on an ALU result in EX.
- br_taken  in  1  branch resolved taken in ID.
- jump  in  1  jump in ID.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register clear, i.e. insert a nop.
- id_ex_bubble  out  1  zero the ID/EX control fields.
- pipe_freeze  out  1  hold all pipeline registers.
- state_o  out  2  current state: 0 RUN, 1 BR_WAIT, 2 MD_WAIT.
- stall_cycles  out  16  saturating count of stall cycles.

## Operation
- Outputs are combinational from the state and inputs. State, countdown and stall_cycles are registered.
- Definition of a stall cycle: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pipe_freeze=0.
- Definition of a normal cycle: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pipe_freeze=0.
- Freeze, any state, mem_wait=1:
  - pipe_freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  - State, countdown and stall_cycles hold.
- RUN, evaluated in this priority order:
  - md_req: stall cycle. If MD_LAT>1, go to MD_WAIT and load cnt=MD_LAT-1; otherwise stay in RUN.
  - br_dep_load: stall cycle, then go to BR_WAIT.
  - load_use or br_dep_alu: stall cycle, stay in RUN.
  - br_taken or jump: normal cycle with if_id_flush=1.
  - None of the above: normal cycle.
- BR_WAIT: stall cycle; all hazard inputs are ignored; next state RUN.
- MD_WAIT: stall cycle; inputs other than mem_wait are ignored. If cnt==1, go to RUN; otherwise cnt decrements.
- Stall beats flush: br_taken/jump is suppressed in any stall cycle. The hazard unit re-presents it once the stall releases.
- stall_cycles increments on every stall cycle and saturates at 0xFFFF without wrapping. Freeze cycles are not counted.

## Timing
- Reset, in the cycle where reset=1:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_freeze=0.
  - Next state RUN, cnt=0, stall_cycles=0, state_o=0.
- Reset mid-sequence, in BR_WAIT or MD_WAIT, abandons the sequence. The cycle after reset deasserts behaves as RUN.
- Latencies:
  - load_use: 1 stall cycle; pc_write returns to 1 the next cycle.
  - br_dep_load: exactly 2 stall cycles, t and t+1.
  - md_req at cycle t: stall cycles t..t+MD_LAT-1; normal cycle at t+MD_LAT.
- Freeze timing: mem_wait during BR_WAIT or MD_WAIT extends the sequence by exactly the number of freeze cycles. The count resumes where it stopped.
- Simultaneous inputs are resolved only by the RUN priority order above. No request is queued.

## Test plan
- Reset, then idle inputs: cycle 0 gives pc_write=1, if_id_write=1, all other outputs 0, stall_cycles=0.
- load_use=1 for one cycle: one stall cycle, then normal; stall_cycles=1.
- br_dep_load and load_use both 1 at cycle t: stalls at t and t+1 with state_o=1 at t+1; normal at t+2; stall_cycles=2.
- md_req at t with MD_LAT=4 and mem_wait=1 at t+2:
  - pipe_freeze=1 at t+2 only.
  - Stall cycles at t, t+1, t+3, t+4; normal at t+5; stall_cycles=4.
- br_taken and br_dep_alu both 1 at t: stall, no flush at t. At t+1 with br_taken=1 only: if_id_flush=1, pc_write=1.
- In MD_WAIT with MD_LAT=8, reset at t+3: RUN at t+4; stall_cycles=0.
- Saturation: preload the counter to 0xFFFE via 65534 load_use stalls, then 3 more stalls: stall_cycles holds at 0xFFFF.
